// File: rtl/icache_line_fill.sv
// Instruction-cache line fill engine: one AXI INCR burst per miss, assembled
// into a full line and offered to the cache, with snoop-driven stale tracking.
module icache_line_fill #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int LINE_BEATS = 8,
    localparam int LINE_W    = DATA_WIDTH * LINE_BEATS
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  fill_valid,
    input  logic                  fill_ready,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [LINE_W-1:0]     fill_data,
    output logic                  fill_err,
    output logic                  fill_stale,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    input  logic                  m_axi_acvalid,
    input  logic [ADDR_WIDTH-1:0] m_axi_acaddr,
    input  logic [3:0]            m_axi_acsnoop,
    output logic                  m_axi_acready
);

    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam int CNT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~((ADDR_WIDTH'(1) << OFF_W) - ADDR_WIDTH'(1));

    typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] line_addr_reg;
    logic [CNT_W-1:0]      beat_cnt_reg;
    logic                  err_reg;
    logic                  stale_reg;

    logic req_fire, ar_fire, beat_fire, beat_last, beat_err, snoop_hit;

    // Response ID and snoop type carry no information for a read-only fill.
    logic unused_inputs;
    assign unused_inputs = ^{m_axi_rid, m_axi_acsnoop};

    assign req_fire  = req_valid && (state_reg == IDLE);
    assign ar_fire   = m_axi_arready && (state_reg == AR);
    assign beat_fire = m_axi_rvalid && (state_reg == R);
    assign beat_last = m_axi_rlast || (beat_cnt_reg == LAST_BEAT);
    // rlast must coincide exactly with the final slot; any mismatch is a protocol error.
    assign beat_err  = (m_axi_rresp != 2'b00) || (m_axi_rlast != (beat_cnt_reg == LAST_BEAT));
    assign snoop_hit = m_axi_acvalid && (state_reg != IDLE)
                       && ((m_axi_acaddr & LINE_MASK) == line_addr_reg);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        req_ready     = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        fill_valid    = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = AR;
            end
            AR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_next = R;
            end
            R: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid && beat_last) state_next = DONE;
            end
            DONE: begin
                fill_valid = 1'b1;
                if (fill_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            line_addr_reg <= '0;
            beat_cnt_reg  <= '0;
            err_reg       <= 1'b0;
            stale_reg     <= 1'b0;
        end else begin
            if (req_fire) begin
                line_addr_reg <= req_addr & LINE_MASK;
                err_reg       <= 1'b0;
                stale_reg     <= 1'b0;
            end
            if (ar_fire) beat_cnt_reg <= '0;
            if (beat_fire) begin
                beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
                if (beat_err) err_reg <= 1'b1;
            end
            if (snoop_hit) stale_reg <= 1'b1;
        end
    end

    // One register per beat slot; slots not reached by a short burst keep old data.
    genvar gi;
    generate
        for (gi = 0; gi < LINE_BEATS; gi++) begin : g_slot
            logic [DATA_WIDTH-1:0] slot_reg;
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    slot_reg <= '0;
                end else if (beat_fire && (beat_cnt_reg == CNT_W'(gi))) begin
                    slot_reg <= m_axi_rdata;
                end
            end
            assign fill_data[gi*DATA_WIDTH +: DATA_WIDTH] = slot_reg;
        end
    endgenerate

    assign fill_addr     = line_addr_reg;
    assign fill_err      = err_reg;
    assign fill_stale    = stale_reg;
    assign m_axi_arid    = '0;
    assign m_axi_araddr  = line_addr_reg;
    assign m_axi_arlen   = 8'(LINE_BEATS - 1);
    assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0000;
    assign m_axi_arprot  = 3'b100;
    assign m_axi_acready = 1'b1;

endmodule

// File: tb/tb_icache_line_fill.sv
// Directed bench for icache_line_fill: drives AXI bursts and snoops, and checks
// each completed fill against a scoreboard of expected lines.
module tb_icache_line_fill;

    localparam int IDW = 13;
    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int LB  = 8;
    localparam int LW  = DW * LB;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid, req_ready;
    logic [AW-1:0] req_addr;
    logic          fill_valid, fill_ready;
    logic [AW-1:0] fill_addr;
    logic [LW-1:0] fill_data;
    logic          fill_err, fill_stale;
    logic [IDW-1:0] arid;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arlock;
    logic [3:0]    arcache;
    logic [2:0]    arprot;
    logic          arvalid, arready;
    logic [IDW-1:0] rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast, rvalid, rready;
    logic          acvalid;
    logic [AW-1:0] acaddr;
    logic [3:0]    acsnoop;
    logic          acready;

    icache_line_fill dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr),
        .fill_data(fill_data), .fill_err(fill_err), .fill_stale(fill_stale),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
        .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arlock(arlock),
        .m_axi_arcache(arcache), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid),
        .m_axi_arready(arready),
        .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .m_axi_acvalid(acvalid), .m_axi_acaddr(acaddr), .m_axi_acsnoop(acsnoop),
        .m_axi_acready(acready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
        logic          err;
        logic          stale;
    } fill_t;

    fill_t         sb_q[$];
    logic [DW-1:0] model_line [LB];
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] model_flat();
        logic [LW-1:0] v;
        for (int k = 0; k < LB; k++) v[k*DW +: DW] = model_line[k];
        return v;
    endfunction

    // Request handshake plus AR channel, leaving the DUT in the R state.
    task automatic issue_req(input logic [AW-1:0] addr, input bit acc_snoop, input int ar_delay);
        logic [AW-1:0] line;
        line = addr & ~64'h3f;
        chk("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_addr  = addr;
        if (acc_snoop) begin
            acvalid = 1'b1;
            acaddr  = addr;
        end
        @(negedge clk);
        req_valid = 1'b0;
        acvalid   = 1'b0;
        chk("arvalid_lat", arvalid, 1'b1);
        chk("req_ready_ar", req_ready, 1'b0);
        chk("araddr", araddr, line);
        chk("arlen", arlen, 8'd7);
        chk("arsize", arsize, 3'd3);
        chk("arid", arid, '0);
        chk("arburst", arburst, 2'b01);
        chk("arprot", arprot, 3'b100);
        chk("arcache_arlock", {arcache, arlock}, 5'b0);
        for (int c = 0; c < ar_delay; c++) begin
            @(negedge clk);
            chk("arvalid_hold", arvalid, 1'b1);
            chk("araddr_hold", araddr, line);
            chk("req_ready_hold", req_ready, 1'b0);
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        chk("arvalid_after_hs", arvalid, 1'b0);
        chk("rready_in_r", rready, 1'b1);
    endtask

    task automatic drive_beat(input int k, input logic [DW-1:0] d, input logic [1:0] resp,
                              input logic last, input bit snoop, input logic [AW-1:0] saddr);
        rvalid = 1'b1;
        rdata  = d;
        rresp  = resp;
        rlast  = last;
        rid    = IDW'(k);
        if (snoop) begin
            acvalid = 1'b1;
            acaddr  = saddr;
        end
        model_line[k] = d;
        @(negedge clk);
        chk("acready", acready, 1'b1);
        rvalid  = 1'b0;
        rlast   = 1'b0;
        acvalid = 1'b0;
    endtask

    // rlast_at: beat index carrying rlast (LB means rlast never asserted).
    task automatic do_fill(input logic [AW-1:0] addr, input int ar_delay, input int bad_beat,
                           input int rlast_at, input logic [AW-1:0] snoop_addr, input int snoop_beat,
                           input int fr_delay, input logic [DW-1:0] base, input bit acc_snoop);
        fill_t e, got;
        int    n_beats;
        bit    exp_err, exp_stale;
        int    waited;
        n_beats   = (rlast_at < LB - 1) ? rlast_at + 1 : LB;
        exp_err   = (bad_beat >= 0 && bad_beat < n_beats) || (rlast_at != LB - 1);
        exp_stale = (snoop_beat >= 0 && snoop_beat < n_beats)
                    && ((snoop_addr & ~64'h3f) == (addr & ~64'h3f));
        issue_req(addr, acc_snoop, ar_delay);
        for (int k = 0; k < n_beats; k++)
            drive_beat(k, base + DW'(k), (k == bad_beat) ? 2'b10 : 2'b00, k == rlast_at,
                       k == snoop_beat, snoop_addr);
        e.addr  = addr & ~64'h3f;
        e.data  = model_flat();
        e.err   = exp_err;
        e.stale = exp_stale;
        sb_q.push_back(e);
        chk("fill_valid_lat", fill_valid, 1'b1);
        waited = 0;
        while (!fill_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        got = sb_q.pop_front();
        chk("fill_addr", fill_addr, got.addr);
        chk("fill_data", fill_data, got.data);
        chk("fill_err", fill_err, got.err);
        chk("fill_stale", fill_stale, got.stale);
        for (int c = 0; c < fr_delay; c++) begin
            @(negedge clk);
            chk("fill_valid_stall", fill_valid, 1'b1);
            chk("fill_data_stall", fill_data, got.data);
            chk("fill_addr_stall", fill_addr, got.addr);
            chk("fill_flags_stall", {fill_err, fill_stale}, {got.err, got.stale});
        end
        fill_ready = 1'b1;
        @(negedge clk);
        fill_ready = 1'b0;
        chk("fill_valid_drop", fill_valid, 1'b0);
        $display("fill addr=%0h beats=%0d err=%0b stale=%0b", got.addr, n_beats, got.err, got.stale);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; fill_ready = 1'b0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
        acvalid = 1'b0; acaddr = '0; acsnoop = 4'h0;
        for (int k = 0; k < LB; k++) model_line[k] = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_outputs", {fill_valid, arvalid, rready, acready}, 4'b0001);
        chk("rst_fill_data", fill_data, '0);
        chk("rst_fill_addr", fill_addr, '0);
        chk("rst_flags", {fill_err, fill_stale}, 2'b00);

        do_fill(64'h1234, 0, -1, 7, 64'h0,    -1, 0, 64'h0,   1'b1);
        do_fill(64'h2008, 5, -1, 7, 64'h0,    -1, 0, 64'hA0,  1'b0);
        do_fill(64'h3000, 0,  3, 7, 64'h0,    -1, 0, 64'h300, 1'b0);
        do_fill(64'h1200, 0, -1, 7, 64'h1238,  2, 0, 64'h400, 1'b0);
        do_fill(64'h1200, 0, -1, 7, 64'h1240,  4, 0, 64'h500, 1'b0);
        do_fill(64'h7000, 0, -1, 5, 64'h0,    -1, 0, 64'h600, 1'b0);
        do_fill(64'h7040, 0, -1, LB, 64'h0,   -1, 0, 64'h700, 1'b0);
        do_fill(64'h8000, 0, -1, 7, 64'h0,    -1, 4, 64'h800, 1'b0);

        // Abandon a burst mid-R with reset; no leftover beats are delivered.
        issue_req(64'h9000, 1'b0, 0);
        for (int k = 0; k < 3; k++) drive_beat(k, 64'h900 + DW'(k), 2'b00, 1'b0, 1'b0, '0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < LB; k++) model_line[k] = '0;
        chk("midrst_fill_valid", fill_valid, 1'b0);
        chk("midrst_arvalid", arvalid, 1'b0);
        chk("midrst_rready", rready, 1'b0);
        chk("midrst_req_ready", req_ready, 1'b1);
        chk("midrst_acready", acready, 1'b1);
        chk("midrst_fill_data", fill_data, '0);
        $display("reset mid-burst at addr=9000");

        do_fill(64'h6040, 0, -1, 1, 64'h0, -1, 0, 64'hB00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_line_fill.md
ICACHE_LINE_FILL -- requirements
Module: icache_line_fill

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 13, AXI ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, AXI data (beat) width.
REQ-004 SHALL have parameter LINE_BEATS, default 8, beats per cache line (power of 2); LINE_W = DATA_WIDTH*LINE_BEATS.
REQ-005 SHALL have ports (one clock; reset synchronous, active-low):
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- req_valid  in  1  miss request valid.
- req_ready  out  1  request accepted.
- req_addr  in  ADDR_WIDTH  miss byte address.
- fill_valid  out  1  line fill available.
- fill_ready  in  1  cache consumes the fill.
- fill_addr  out  ADDR_WIDTH  line-aligned address of the fill.
- fill_data  out  LINE_W  line data, beat k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- fill_err  out  1  any non-OKAY rresp or burst-length violation.
- fill_stale  out  1  snoop hit the line while the fill was in flight.
- m_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3/1  AXI read-address channel.
- m_axi_arready  in  1.
- m_axi_rid/rdata/rresp/rlast/rvalid  in  ID_WIDTH/DATA_WIDTH/2/1/1  AXI read-data channel.
- m_axi_rready  out  1.
- m_axi_acvalid  in  1; m_axi_acaddr  in  ADDR_WIDTH; m_axi_acsnoop  in  4; m_axi_acready  out  1  snoop channel.

Function
REQ-006 SHALL implement FSM IDLE, AR, R, DONE.
REQ-007 IDLE: req_ready=1; req_valid&&req_ready latches line address (req_addr with low log2(LINE_W/8) bits cleared), clears err/stale, goes AR next cycle.
REQ-008 AR: m_axi_arvalid=1; AR payload held constant until m_axi_arready; on handshake go R, beat counter=0.
REQ-009 AR payload SHALL be: arid=0 (bit 0 must be 0 so responses route to icache), araddr=latched line address, arlen=LINE_BEATS-1, arsize=log2(DATA_WIDTH/8), arburst=2'b01 (INCR), arlock=0, arcache=4'b0000, arprot=3'b100 (instruction).
REQ-010 R: m_axi_rready=1; each rvalid beat written to line slot indexed by counter, counter increments; rid not checked.
REQ-011 Any beat with rresp!=2'b00 SHALL set err (sticky until next request).
REQ-012 Burst ends on first beat with rlast=1 or on beat LINE_BEATS-1, whichever first; then go DONE.
REQ-013 rlast=1 on beat index < LINE_BEATS-1, or rlast=0 on beat LINE_BEATS-1, SHALL set err; unfilled slots keep previous contents.
REQ-014 DONE: fill_valid=1; fill_addr/fill_data/fill_err/fill_stale held stable until fill_ready; on fill_valid&&fill_ready go IDLE.
REQ-015 No new request accepted until DONE handshake completes (req_ready=0 in AR, R, DONE); max one outstanding burst.
REQ-016 m_axi_acready SHALL be constant 1 (never stall the interconnect's AND-combined acready).
REQ-017 In AR, R or DONE, m_axi_acvalid with line-aligned acaddr equal to latched line address SHALL set stale (sticky); acsnoop ignored; snoop in IDLE ignored.
REQ-018 Snoop in the same cycle as request acceptance SHALL not set stale.
REQ-019 m_axi_rready=0 outside R; m_axi_arvalid=0 outside AR.
REQ-020 Request-to-AR latency: arvalid asserted cycle after acceptance; fill_valid asserted cycle after final beat.

Reset
REQ-021 reset_n=0 at a clock edge SHALL force IDLE, counter=0, err=0, stale=0, fill_data=0, fill_addr=0; outputs: req_ready=1 after reset, fill_valid=0, arvalid=0, rready=0, acready=1.
REQ-022 Reset mid-burst SHALL abandon the burst; the bench SHALL not deliver leftover beats after reset.

Verification
REQ-023 req_addr=0x1234, arready=1 immediately, 8 OKAY beats 0..7 with rlast on beat 7 -> araddr=0x1200, arlen=7, arsize=3, arid=0; fill_data beat k = k; fill_err=0, fill_stale=0.
REQ-024 arready held low 5 cycles -> AR payload and arvalid stable throughout; req_ready=0; then normal completion.
REQ-025 beat 3 rresp=2'b10 -> fill_err=1, all 8 beats stored; next request clears err.
REQ-026 rlast on beat 5 -> DONE after beat 5, fill_err=1; rlast=0 on beat 7 -> DONE after beat 7, fill_err=1.
REQ-027 snoop acaddr=0x1238 during R for line 0x1200 -> fill_stale=1, acready=1 throughout; snoop 0x1240 -> fill_stale=0.
REQ-028 fill_ready low 4 cycles in DONE, then reset asserted mid-R of next request -> fill outputs stable during stall; after reset fill_valid=0, arvalid=0, req_ready=1.
